// File: rtl/dmem_dma_copier.sv
// Word-copy DMA initiator on the data-memory port: one word read then one word write per word,
// advancing source and destination by 4 until the requested length is moved.
module dmem_dma_copier #(
  parameter int unsigned LenW     = 16,
  parameter logic [2:0]  Funct3Lw = 3'b010
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [31:0]     src_addr_i,
  input  logic [31:0]     dst_addr_i,
  input  logic [LenW-1:0] length_i,
  input  logic            grant_i,
  output logic            req_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            error_o,
  output logic [31:0]     mem_addr_o,
  output logic [31:0]     mem_write_data_o,
  output logic            mem_write_o,
  output logic [2:0]      mem_funct3_o,
  input  logic [31:0]     mem_read_data_i
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e          state_q, state_d;
  logic [31:0]     src_q, src_d;
  logic [31:0]     dst_q, dst_d;
  logic [LenW-1:0] cnt_q, cnt_d;
  logic [31:0]     buf_q, buf_d;
  logic            err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    src_d            = src_q;
    dst_d            = dst_q;
    cnt_d            = cnt_q;
    buf_d            = buf_q;
    err_d            = 1'b0;
    req_o            = 1'b0;
    busy_o           = 1'b0;
    done_o           = 1'b0;
    mem_addr_o       = '0;
    mem_write_data_o = '0;
    mem_write_o      = 1'b0;
    mem_funct3_o     = Funct3Lw;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if ((src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00)) begin
            err_d = 1'b1;
          end else if (length_i == '0) begin
            state_d = StDone;
          end else begin
            src_d   = src_addr_i;
            dst_d   = dst_addr_i;
            cnt_d   = length_i;
            state_d = StRead;
          end
        end
      end
      StRead: begin
        req_o  = 1'b1;
        busy_o = 1'b1;
        if (grant_i) begin
          mem_addr_o = src_q;
          buf_d      = mem_read_data_i;
          src_d      = src_q + 32'd4;
          state_d    = StWrite;
        end
      end
      StWrite: begin
        req_o  = 1'b1;
        busy_o = 1'b1;
        // Without grant the buffered word is held, so the copy resumes without a re-read.
        if (grant_i) begin
          mem_addr_o       = dst_q;
          mem_write_data_o = buf_q;
          mem_write_o      = 1'b1;
          dst_d            = dst_q + 32'd4;
          cnt_d            = cnt_q - LenW'(1);
          state_d          = (cnt_q == LenW'(1)) ? StDone : StRead;
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign error_o = err_q;

endmodule
